tile_game: RTL and testbench

- Top-level memory/tile-matching game for the DE1-SoC board: 10 hidden tiles, one per slide switch, holding 5 symbol pairs.
- Player starts a game with KEY[1] and flips tiles by raising switches. Matched pairs light LEDs; picks, pair count and attempt count show on the seven-segment displays.
- Sits directly on board pins; no submodule interface.

---
 rtl/tile_game.sv | 194 +++++++++++++++++++
 tb/tb_tile_game.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/tile_game.sv
// Ten-tile memory/pair-matching game for the DE1-SoC board (KEY[0] is the async reset).
// Optional cheat hint on LEDR is enabled by defining TILE_GAME_CHEAT_EN.
module tile_game #(
   parameter int REVEAL_CYCLES = 25_000_000,
   parameter int OFFSET_STEP   = 3
) (
   input  logic [9:0] SW,
   input  logic [3:0] KEY,
   input  logic       CLOCK_50,
   output logic [9:0] LEDR,
   output logic [6:0] HEX0,
   output logic [6:0] HEX1,
   output logic [6:0] HEX2,
   output logic [6:0] HEX3,
   output logic [6:0] HEX4,
   output logic [6:0] HEX5
);
   typedef enum logic [2:0] {S_IDLE, S_PICK1, S_PICK2, S_CHECK, S_REVEAL, S_WIN} state_t;

   localparam int CW = (REVEAL_CYCLES > 1) ? $clog2(REVEAL_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(REVEAL_CYCLES - 1);
   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_DASH  = 7'h3F;

   // MAP = {0,1,2,3,4,0,1,2,3,4} reduces to ((i+off) mod 10) mod 5
   function automatic logic [2:0] tile_val(input logic [3:0] t, input logic [3:0] off);
      logic [4:0] s;
      s = {1'b0, t} + {1'b0, off};
      if (s >= 5'd10) s = s - 5'd10;
      if (s >= 5'd5)  s = s - 5'd5;
      return s[2:0];
   endfunction

   function automatic logic [6:0] seg(input logic [6:0] d);
      case (d)
         7'd0: seg = 7'h40;  7'd1: seg = 7'h79;  7'd2: seg = 7'h24;
         7'd3: seg = 7'h30;  7'd4: seg = 7'h19;  7'd5: seg = 7'h12;
         7'd6: seg = 7'h02;  7'd7: seg = 7'h78;  7'd8: seg = 7'h00;
         7'd9: seg = 7'h10;  default: seg = SEG_BLANK;
      endcase
   endfunction

   logic rst_n;
   assign rst_n = KEY[0];

   logic [9:0] sw_s1, sw_s2, sw_d;
   logic [3:1] key_s1, key_s2;
   logic       key1_d;

   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) begin
         sw_s1 <= '0;  sw_s2 <= '0;  sw_d <= '0;
         key_s1 <= '1; key_s2 <= '1; key1_d <= 1'b1;
      end else begin
         sw_s1  <= SW;
         sw_s2  <= sw_s1;
         sw_d   <= sw_s2;
         key_s1 <= KEY[3:1];
         key_s2 <= key_s1;
         key1_d <= key_s2[1];
      end
   end

   logic [9:0] flip_edge;
   logic       start;
   assign flip_edge = sw_s2 & ~sw_d;
   assign start     = key1_d & ~key_s2[1];

   state_t      state, state_nxt;
   logic [9:0]  matched;
   logic [6:0]  attempts;
   logic [2:0]  pairs;
   logic [3:0]  offset, cur_off, pick_a, pick_b;
   logic        has_a, has_b;
   logic [CW-1:0] cnt;

   // Lowest-index edge wins; a losing or invalid edge is simply dropped
   logic       flip_any, flip_ok;
   logic [3:0] flip_idx;
   always_comb begin
      flip_any = 1'b0;
      flip_idx = '0;
      for (int i = 9; i >= 0; i--) begin
         if (flip_edge[i]) begin
            flip_any = 1'b1;
            flip_idx = 4'(i);
         end
      end
   end
   assign flip_ok = flip_any && !matched[flip_idx] && !(state == S_PICK2 && flip_idx == pick_a);

   logic is_match, cnt_done;
   assign is_match = tile_val(pick_a, cur_off) == tile_val(pick_b, cur_off);
   assign cnt_done = cnt == CNT_LAST;

   logic [4:0] off_sum;
   always_comb begin
      off_sum = {1'b0, offset} + 5'(OFFSET_STEP % 10);
      if (off_sum >= 5'd10) off_sum = off_sum - 5'd10;
   end

   always_comb begin
      state_nxt = state;
      if (start) state_nxt = S_PICK1;
      else begin
         case (state)
            S_PICK1:  if (flip_ok) state_nxt = S_PICK2;
            S_PICK2:  if (flip_ok) state_nxt = S_CHECK;
            S_CHECK:  state_nxt = is_match ? ((pairs == 3'd4) ? S_WIN : S_PICK1) : S_REVEAL;
            S_REVEAL: if (cnt_done) state_nxt = S_PICK1;
            default:  state_nxt = state;
         endcase
      end
   end

   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) begin
         matched <= '0; attempts <= '0; pairs <= '0;
         offset <= '0; cur_off <= '0; pick_a <= '0; pick_b <= '0;
         has_a <= 1'b0; has_b <= 1'b0; cnt <= '0;
      end else if (start) begin
         matched <= '0; attempts <= '0; pairs <= '0;
         has_a <= 1'b0; has_b <= 1'b0;
         cur_off <= offset;
         offset  <= off_sum[3:0];
      end else begin
         case (state)
            S_PICK1: if (flip_ok) begin
               pick_a <= flip_idx;
               has_a  <= 1'b1;
            end
            S_PICK2: if (flip_ok) begin
               pick_b <= flip_idx;
               has_b  <= 1'b1;
               if (attempts != 7'd99) attempts <= attempts + 7'd1;
            end
            S_CHECK: if (is_match) begin
               matched <= matched | (10'd1 << pick_a) | (10'd1 << pick_b);
               pairs   <= pairs + 3'd1;
               has_a   <= 1'b0;
               has_b   <= 1'b0;
            end else cnt <= '0;
            S_REVEAL: if (cnt_done) begin
               has_a <= 1'b0;
               has_b <= 1'b0;
            end else cnt <= cnt + 1'b1;
            default: ;
         endcase
      end
   end

   logic [9:0] hint;
`ifdef TILE_GAME_CHEAT_EN
   always_comb begin
      hint = '0;
      if (state == S_PICK2 && !key_s2[3]) begin
         for (int j = 0; j < 10; j++) begin
            if (4'(j) != pick_a && !matched[j] &&
                tile_val(4'(j), cur_off) == tile_val(pick_a, cur_off))
               hint[j] = 1'b1;
         end
      end
   end
`else
   assign hint = '0;
`endif

   logic [6:0] att_ones, att_tens;
   assign att_ones = attempts % 7'd10;
   assign att_tens = attempts / 7'd10;

   always_comb begin
      HEX0 = SEG_DASH; HEX1 = SEG_DASH; HEX2 = SEG_DASH;
      HEX3 = SEG_DASH; HEX4 = SEG_DASH; HEX5 = SEG_DASH;
      LEDR = matched | hint;
      if (state != S_IDLE) begin
         HEX0 = has_a ? seg({4'd0, tile_val(pick_a, cur_off)}) : SEG_BLANK;
         HEX1 = has_b ? seg({4'd0, tile_val(pick_b, cur_off)}) : SEG_BLANK;
         HEX2 = seg({4'd0, pairs});
         HEX3 = SEG_BLANK;
         HEX4 = seg(att_ones);
         HEX5 = seg(att_tens);
         if (state == S_WIN) LEDR = 10'h3FF;
      end
   end

   logic unused_ok;
   assign unused_ok = &{1'b0, key_s2[3:2], off_sum[4]};
endmodule

// File: tb/tb_tile_game.sv
// Randomized + directed bench for tile_game against a flip-level game model.
module tb_tile_game;
   localparam int RC = 8;

   logic       clk = 1'b0;
   logic [9:0] sw;
   logic [3:0] key;
   logic [9:0] ledr;
   logic [6:0] h0, h1, h2, h3, h4, h5;

   tile_game #(.REVEAL_CYCLES(RC), .OFFSET_STEP(3)) dut (
      .SW(sw), .KEY(key), .CLOCK_50(clk), .LEDR(ledr),
      .HEX0(h0), .HEX1(h1), .HEX2(h2), .HEX3(h3), .HEX4(h4), .HEX5(h5)
   );

   always #10 clk = ~clk;

   int vectors = 0, miscompares = 0;
   int         map [10] = '{0, 1, 2, 3, 4, 0, 1, 2, 3, 4};
   logic [6:0] segtab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

   // Game model: 0 idle, 1 waiting first pick, 2 waiting second, 3 showing mismatch, 4 won
   int       ms, m_off, m_coff, m_att, m_pairs, m_a, m_b;
   bit       m_ha, m_hb;
   bit [9:0] m_mat;

   function automatic int mval(int t);
      return map[(t + m_coff) % 10];
   endfunction

   task automatic m_reset();
      ms = 0; m_off = 0; m_coff = 0; m_att = 0; m_pairs = 0;
      m_a = 0; m_b = 0; m_ha = 0; m_hb = 0; m_mat = '0;
   endtask

   task automatic m_start();
      m_coff = m_off; m_off = (m_off + 3) % 10;
      m_att = 0; m_pairs = 0; m_ha = 0; m_hb = 0; m_mat = '0; ms = 1;
   endtask

   task automatic m_flip(int t);
      if (ms == 1 && !m_mat[t]) begin
         m_a = t; m_ha = 1; ms = 2;
      end else if (ms == 2 && !m_mat[t] && t != m_a) begin
         m_b = t; m_hb = 1;
         if (m_att < 99) m_att++;
         if (mval(m_a) == mval(m_b)) begin
            m_mat[m_a] = 1'b1; m_mat[m_b] = 1'b1; m_pairs++;
            m_ha = 0; m_hb = 0;
            ms = (m_pairs == 5) ? 4 : 1;
         end else ms = 3;
      end
   endtask

   task automatic chk(string tag, logic [9:0] obs, logic [9:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_all(string tag);
      logic [6:0] e0, e1, e2, e3, e4, e5;
      logic [9:0] el;
      if (ms == 0) begin
         e0 = 7'h3F; e1 = 7'h3F; e2 = 7'h3F; e3 = 7'h3F; e4 = 7'h3F; e5 = 7'h3F; el = '0;
      end else begin
         e0 = m_ha ? segtab[mval(m_a)] : 7'h7F;
         e1 = m_hb ? segtab[mval(m_b)] : 7'h7F;
         e2 = segtab[m_pairs];
         e3 = 7'h7F;
         e4 = segtab[m_att % 10];
         e5 = segtab[m_att / 10];
         el = m_mat;
      end
      chk({tag, "/hex0"}, {3'b0, h0}, {3'b0, e0});
      chk({tag, "/hex1"}, {3'b0, h1}, {3'b0, e1});
      chk({tag, "/hex2"}, {3'b0, h2}, {3'b0, e2});
      chk({tag, "/hex3"}, {3'b0, h3}, {3'b0, e3});
      chk({tag, "/hex4"}, {3'b0, h4}, {3'b0, e4});
      chk({tag, "/hex5"}, {3'b0, h5}, {3'b0, e5});
      chk({tag, "/ledr"}, ledr, el);
   endtask

   task automatic tick(int n);
      repeat (n) @(negedge clk);
   endtask

   // Raise a set of switches together; the model sees only the lowest one
   task automatic raise_set(logic [9:0] mask, int wait_cyc, string tag);
      int first;
      first = -1;
      for (int i = 9; i >= 0; i--) if (mask[i]) first = i;
      sw = sw | mask;
      tick(wait_cyc);
      if (first >= 0) m_flip(first);
      check_all(tag);
   endtask

   task automatic do_flip(int t, string tag);
      if (sw[t]) begin
         sw[t] = 1'b0;
         tick(3);
      end
      raise_set(10'd1 << t, 6, tag);
   endtask

   task automatic finish_reveal(string tag);
      if (ms == 3) begin
         tick(RC + 2);
         m_ha = 0; m_hb = 0; ms = 1;
         check_all(tag);
      end
   endtask

   task automatic start_game(string tag);
      key[1] = 1'b0;
      tick(4);
      key[1] = 1'b1;
      tick(4);
      m_start();
      check_all(tag);
   endtask

   task automatic do_reset(string tag);
      key[0] = 1'b0;
      #1;
      m_reset();
      check_all(tag);
      tick(2);
      key[0] = 1'b1;
      tick(2);
   endtask

   initial begin
      int t, steps;
      sw = '0;
      key = 4'b1111;
      m_reset();
      tick(1);

      // Reset state and flips ignored while idle
      do_reset("reset0");
      do_flip(3, "idle_flip");

      // First game, offset 0: mismatch 1/2 then reveal timeout
      start_game("start0");
      raise_set(10'd1 << 1, 4, "lat_pick1");
      chk("lat_hex0_lit", {3'b0, h0}, 10'h079);
      do_flip(2, "mismatch12");
      chk("mm_hex1_lit", {3'b0, h1}, 10'h024);
      chk("mm_att1", {3'b0, h4}, 10'h079);
      finish_reveal("reveal_end");

      // Fresh game at offset 0: pair (0,5), then complete all pairs
      do_reset("reset1");
      start_game("start1");
      do_flip(0, "p0");
      do_flip(5, "p5");
      chk("pair05_led", ledr, 10'b0000100001);
      for (int k = 1; k < 5; k++) begin
         do_flip(k, "pa");
         do_flip(k + 5, "pb");
      end
      chk("win_led", ledr, 10'h3FF);
      chk("win_pairs", {3'b0, h2}, 10'h012);

      // Restart: offset moves to 3, tiles 0 and 5 now hold 3
      start_game("start2");
      do_flip(0, "off3_t0");
      chk("off3_val", {3'b0, h0}, 10'h030);
      do_flip(5, "off3_t5");

      // Simultaneous edges, matched and first-pick re-flips
      sw = '0;
      tick(3);
      raise_set((10'd1 << 3) | (10'd1 << 7), 6, "simul37");
      do_flip(0, "matched_reflip");
      do_flip(3, "same_tile");
      do_flip(2, "mismatch32");
      sw[4] = 1'b1;
      finish_reveal("reveal_discard");

      // Reset in the middle of a reveal
      do_flip(1, "pre_rst_a");
      do_flip(2, "pre_rst_b");
      do_reset("reset_reveal");

      // Attempt counter saturates at 99
      start_game("start_sat");
      for (int k = 0; k < 101; k++) begin
         do_flip(0, "sat_a");
         do_flip(1, "sat_b");
         finish_reveal("sat_rev");
      end
      chk("sat_ones", {3'b0, h4}, 10'h010);
      chk("sat_tens", {3'b0, h5}, 10'h010);

      // Random games with a bias toward the partner tile
      for (int g = 0; g < 4; g++) begin
         start_game("rstart");
         steps = 0;
         while (ms != 4 && steps < 60) begin
            t = $urandom_range(9, 0);
            if (ms == 2 && $urandom_range(1, 0) == 1) begin
               for (int j = 0; j < 10; j++)
                  if (j != m_a && mval(j) == mval(m_a)) t = j;
            end
            key[3] = 1'($urandom_range(1, 0));
            do_flip(t, "rflip");
            finish_reveal("rrev");
            steps++;
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
